// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder and its carry-select slice.
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN (used by nibble_serial_adder).
package nsa_pkg;

    // Width of one slice; the adder walks the operands in steps of this size.
    localparam int NIBBLE_W = 4;

    // Control states of the sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_csa4_slice.sv
// csa4_slice: combinational 4-bit carry-select adder slice.
// Two ripple adders compute the nibble sum for carry-in 0 and carry-in 1 in
// parallel; the real carry-in only steers the final mux, so it does not have
// to ripple through the nibble.
module csa4_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0]   c0_chain;
    logic [NIBBLE_W:0]   c1_chain;
    logic [NIBBLE_W-1:0] s0;
    logic [NIBBLE_W-1:0] s1;

    assign c0_chain[0] = 1'b0;
    assign c1_chain[0] = 1'b1;

    // Full-adder cells for both speculative ripple chains.
    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
            assign s0[gi]         = a[gi] ^ b[gi] ^ c0_chain[gi];
            assign c0_chain[gi+1] = (a[gi] & b[gi]) | (a[gi] & c0_chain[gi]) | (b[gi] & c0_chain[gi]);
            assign s1[gi]         = a[gi] ^ b[gi] ^ c1_chain[gi];
            assign c1_chain[gi+1] = (a[gi] & b[gi]) | (a[gi] & c1_chain[gi]) | (b[gi] & c1_chain[gi]);
        end
    endgenerate

    // Carry-in selects which precomputed result leaves the slice.
    always_comb begin
        s  = ci ? s1 : s0;
        co = ci ? c1_chain[NIBBLE_W] : c0_chain[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit unsigned adder that processes one nibble per
// clock through a single time-shared csa4_slice, LSB nibble first, with the
// carry held in a register between nibbles.
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN adds a registered
// two's-complement overflow output (ovf).
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    // Operands must split into whole nibbles.
    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH (%0d) must be a multiple of 4 and >= 4", WIDTH);
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
    logic               carry_into_msb;
`endif

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    // Present the nibble selected by the counter to the shared slice.
    always_comb begin
        slice_a = op_a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
        slice_b = op_b_q[NIBBLE_W*cnt_q +: NIBBLE_W];
    end

    csa4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // The carry into the top bit of the slice is recovered from the sum bit:
    // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
    always_comb begin
        carry_into_msb = slice_a[NIBBLE_W-1] ^ slice_b[NIBBLE_W-1] ^ slice_s[NIBBLE_W-1];
    end
`endif

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                // in_ready is high here, so in_valid alone means acceptance.
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[NIBBLE_W*cnt_q +: NIBBLE_W] = slice_s;
                carry_d = slice_co;
                if (cnt_q == CNT_LAST) begin
                    co_d    = slice_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_into_msb ^ slice_co;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result is held until the consumer takes it; no new operands.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any add in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        co        = co_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: directed cases plus a randomized stream,
// checked by a queue-based scoreboard fed from an arithmetic reference model.
// Honours NIBBLE_SERIAL_ADDER_OVF_EN when the design is built with it.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_acc     = 0;
    int   n_ret     = 0;
    int   n_dropped = 0;

    // Reference: plain integer arithmetic, unsigned for sum/co, signed range
    // test for overflow.
    function automatic exp_t model(logic [W-1:0] xa, logic [W-1:0] xb, logic xci);
        exp_t   e;
        longint ua, ub, tot, sa, sb, sres;
        ua  = longint'(xa);
        ub  = longint'(xb);
        tot = ua + ub + longint'(xci);
        sa  = (ua >= (longint'(1) << (W-1))) ? ua - (longint'(1) << W) : ua;
        sb  = (ub >= (longint'(1) << (W-1))) ? ub - (longint'(1) << W) : ub;
        sres = sa + sb + longint'(xci);
        e.a   = xa;
        e.b   = xb;
        e.ci  = xci;
        e.sum = W'(tot % (longint'(1) << W));
        e.co  = (tot >= (longint'(1) << W));
        e.ovf = (sres > (longint'(1) << (W-1)) - 1) || (sres < -(longint'(1) << (W-1)));
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_dropped += sb_q.size();
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, ci));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    n_ret++;
                    check("sb_sum", sum, e.sum);
                    check("sb_co", co, e.co);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    check("sb_ovf", ovf, e.ovf);
`endif
                    $display("txn %0d: 0x%04h + 0x%04h + %0d -> sum=0x%04h co=%0d (exp 0x%04h/%0d)",
                             n_ret, e.a, e.b, e.ci, sum, co, e.sum, e.co);
                end
            end
        end
    end

    // Absolute time bound for the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_in_ready(input string name);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check(name, 0, 1);
    endtask

    // One directed add with explicit expected values, optional backpressure.
    task automatic directed(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xci,
                            input logic [W-1:0] exp_sum, input logic exp_co, input logic exp_ovf,
                            input int hold);
        int           lat;
        logic [W-1:0] held_sum;
        logic         held_co;
        out_ready = 1'b0;
        a = xa; b = xb; ci = xci; in_valid = 1'b1;
        wait_in_ready("dir_in_ready_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dir_latency", lat, NIB);
        check("dir_sum", sum, exp_sum);
        check("dir_co", co, exp_co);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("dir_ovf", ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) check("dir_ovf_arg", 0, 1);
`endif
        held_sum = sum;
        held_co  = co;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
            check("bp_sum_stable", sum, held_sum);
            check("bp_co_stable", co, held_co);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int   sent;
        int   cyc;
        logic will_accept;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        directed(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        directed(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 5);
        directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);

        // Reset in the second RUN cycle must abort the add.
        a = 16'hABCD; b = 16'h1111; ci = 1'b1; in_valid = 1'b1;
        wait_in_ready("rst_test_in_ready_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_co", co, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_out_valid", out_valid, 0);
        end
        directed(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        // Random stream: operands change every cycle, in_valid/out_ready random.
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while ((sent < 1000 || sb_q.size() != 0 || !in_ready) && cyc < 40000) begin
            will_accept = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (will_accept) sent++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000) begin
                in_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 5))
                    0:       a = '1;
                    1:       a = '0;
                    default: a = W'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       b = '1;
                    1:       b = 16'h0001;
                    default: b = W'($urandom);
                endcase
                ci = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
        end
        if (cyc >= 40000) check("random_cycle_budget", cyc, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("random_sent", sent, 1000);
        check("sb_empty", sb_q.size(), 0);
        check("txn_count", n_ret, n_acc - n_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that adds one 4-bit nibble per clock through a 4-bit carry-select slice.
- Carry is registered between cycles, LSB nibble first.
- Sits downstream of the team's 4-bit carry-select adder: it sequences operands into that slice and collects the nibble sums and carry it produces.
- Trades latency for area when wide adds are not timing-critical.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIB, WIDTH/4, derived nibble count; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand handshake valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, sampled on acceptance.
- b  input  WIDTH  operand B, sampled on acceptance.
- ci  input  1  carry-in, sampled on acceptance.
- out_valid  output  1  result handshake valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- co  output  1  registered carry-out of MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: rst_n low at a rising edge gives state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, co=0; internal operand/carry/count registers = 0.
- Reset mid-operation aborts the operation and discards the result; no out_valid pulse.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, ci into op_a, op_b, carry; cnt=0; go to RUN.
  - in_valid without acceptance has no effect.
- RUN:
  - in_ready=0.
  - Each cycle, slice inputs = op_a[4*cnt+:4], op_b[4*cnt+:4], carry.
  - Write the slice sum to sum[4*cnt+:4]; load the slice carry-out into carry.
  - If cnt==NIB-1: co<=slice carry-out, go to DONE. Else cnt<=cnt+1.
- DONE:
  - out_valid=1; sum/co held stable until handshake.
  - On out_ready: go to IDLE and clear out_valid.
  - New operands are not accepted in DONE (no overlap).
- Latency: acceptance edge at cycle k gives out_valid high from cycle k+NIB. Throughput is one add per NIB+2 cycles with out_ready tied high.
- sum is partially updated during RUN; it is valid only while out_valid=1.
- Arithmetic: {co,sum} = a + b + ci, modulo 2^(WIDTH+1), unsigned.
- WIDTH not a multiple of 4, or < 4: elaboration-time error.
- NIB=1 degenerate case: exactly one RUN cycle.
- cnt width: $clog2(NIB), minimum 1 bit.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - In the final RUN cycle: ovf <= carry-into-MSB XOR slice carry-out, i.e. two's-complement signed overflow.
  - Held with sum in DONE.
- Undefined: no ovf port and no associated logic; the port list is otherwise identical.

Decomposition:
- Shared package nsa_pkg: FSM state enum (IDLE, RUN, DONE), NIBBLE_W=4 constant.
- One natural sub-module: csa4_slice, a combinational 4-bit carry-select slice (two ripple 4-bit adders with ci=0/1, mux on carry-in).
  - Instantiated once and time-shared across nibbles.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, ci=0 -> sum=0x5555, co=0; out_valid exactly 4 cycles after acceptance edge.
- a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1 (carry ripples through all nibbles); then a=0xFFFF, b=0x0000, ci=1 -> sum=0x0000, co=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> sum/co stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle, in_ready=1.
- rst_n low during 2nd RUN cycle -> next cycle all outputs at reset values, state IDLE; next add 0x0F0F+0x00F1 -> 0x1000, co=0.
- With NIBBLE_SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, co=0; 0xFFFF+0x0001 -> ovf=0, co=1.
- Random back-to-back stream of 1000 adds, in_valid/out_ready randomized: every result matches a+b+ci; no lost or duplicated transactions.
